memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter MEM_DEPTH_W, default 10: log2 of data RAM depth in words.
REQ-002 Parameters DATA_W, RSV_ID_W, INSTR_W, CDB_W taken from fcpu_pkg; CDB_W = RSV_ID_W+DATA_W.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  memory request valid.
REQ-006 i_opcode  input  INSTR_W  request opcode (fcpu_pkg I_* encoding).
REQ-007 i_rsv_id  input  RSV_ID_W  ROB id of request.
REQ-008 i_address  input  DATA_W  computed word address.
REQ-009 i_data  input  DATA_W  store/output data.
REQ-010 i_ready  output  1  request accepted when i_valid & i_ready at clk edge.
REQ-011 o_cdb  output  CDB_W  {rsv_id, data} result broadcast.
REQ-012 o_cdb_valid  output  1  result valid.
REQ-013 o_cdb_ready  input  1  CDB arbiter grant.
REQ-014 in_valid / in_data / in_ready  input 1 / input 8 / output 1  external input byte stream.
REQ-015 out_valid / out_data / out_ready  output 1 / output 8 / input 1  external output byte stream.

Function
REQ-016 Opcode classes: LOAD = {I_LOAD, I_LOADB, I_LOADR, I_LOADT, I_LOADTB}; STORE = {I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB}; I_INPUT; I_OUTPUT; any other opcode is accepted and discarded, no side effect.
REQ-017 Single outstanding request; FSM states IDLE, READ, RESP, IN_WAIT, OUT_WAIT; i_ready = 1 only in IDLE.
REQ-018 RAM index = i_address[MEM_DEPTH_W-1:0]; address in range iff i_address[DATA_W-1:MEM_DEPTH_W] == 0.
REQ-019 STORE accepted at edge k: RAM word written at edge k if in range, dropped otherwise; FSM stays IDLE; no CDB response; back-to-back stores at 1/cycle.
REQ-020 LOAD accepted at edge k: IDLE->READ; at edge k+1 response register <= {i_rsv_id, RAM word} (0 if out of range), READ->RESP; o_cdb_valid high from edge k+1.
REQ-021 RESP: o_cdb and o_cdb_valid held stable until edge with o_cdb_ready=1, then RESP->IDLE, o_cdb_valid low after that edge.
REQ-022 Load following a store to same index in the next cycle SHALL return the stored value.
REQ-023 I_INPUT accepted: IDLE->IN_WAIT; in_ready = 1 only in IN_WAIT; on in_valid & in_ready edge capture {rsv_id, zero-extended in_data} and go RESP.
REQ-024 I_OUTPUT accepted: IDLE->OUT_WAIT with out_data = i_data[7:0] registered; out_valid = 1 only in OUT_WAIT; on out_ready edge -> IDLE; no CDB response.
REQ-025 o_cdb_valid, in_ready, out_valid never asserted in IDLE.
REQ-026 Unused opcode bits and i_data ignored for LOAD/INPUT.

Reset
REQ-027 rst asserted: immediately (no clock) FSM = IDLE, o_cdb = 0, o_cdb_valid = 0, in_ready = 0, out_valid = 0, out_data = 0; i_ready = 1 once rst deasserts.
REQ-028 Reset mid-operation abandons any pending request without response; RAM contents not cleared.
REQ-029 Request presented during rst is not accepted.

Verification
REQ-030 STORE addr 0x10 data 0xDEADBEEF, next cycle LOAD addr 0x10 rsv_id 3 -> o_cdb = {3, 0xDEADBEEF}, o_cdb_valid rises one cycle after load acceptance edge.
REQ-031 LOAD with o_cdb_ready held 0 for 5 cycles -> o_cdb stable 5 cycles, i_ready 0 throughout, released on first ready edge.
REQ-032 LOAD addr 1<<MEM_DEPTH_W -> o_cdb data 0; prior STORE to same address leaves index 0 unchanged.
REQ-033 I_INPUT rsv_id 5, in_data 0x41 after 3-cycle delay -> o_cdb = {5, 0x00000041}; I_OUTPUT data 0x1234 -> out_data 0x34 held until out_ready, no o_cdb_valid.
REQ-034 Assert rst asynchronously in RESP -> o_cdb_valid low before next edge, FSM IDLE, no response issued after release.

Source files
------------

// File: rtl/memory_responder.sv
// Memory/IO responder for the fcpu back end: serves RAM loads and stores plus
// byte-stream input/output requests, and returns load/input results on the CDB.

package fcpu_pkg;
    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_NOP     = 6'd0;
    localparam logic [INSTR_W-1:0] I_LOAD    = 6'd1;
    localparam logic [INSTR_W-1:0] I_LOADB   = 6'd2;
    localparam logic [INSTR_W-1:0] I_LOADR   = 6'd3;
    localparam logic [INSTR_W-1:0] I_LOADT   = 6'd4;
    localparam logic [INSTR_W-1:0] I_LOADTB  = 6'd5;
    localparam logic [INSTR_W-1:0] I_STORE   = 6'd6;
    localparam logic [INSTR_W-1:0] I_STOREB  = 6'd7;
    localparam logic [INSTR_W-1:0] I_STORER  = 6'd8;
    localparam logic [INSTR_W-1:0] I_STORET  = 6'd9;
    localparam logic [INSTR_W-1:0] I_STORETB = 6'd10;
    localparam logic [INSTR_W-1:0] I_INPUT   = 6'd11;
    localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'd12;
    localparam logic [INSTR_W-1:0] I_ADD     = 6'd13;
endpackage

module memory_responder
    import fcpu_pkg::*;
#(
    parameter int MEM_DEPTH_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [INSTR_W-1:0]  i_opcode,
    input  logic [RSV_ID_W-1:0] i_rsv_id,
    input  logic [DATA_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_data,
    output logic                i_ready,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    input  logic                out_ready
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        RESP,
        IN_WAIT,
        OUT_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0]      mem [2**MEM_DEPTH_W];
    logic [MEM_DEPTH_W-1:0] req_idx;
    logic                   req_in_range;
    logic [RSV_ID_W-1:0]    req_rsv;
    logic [CDB_W-1:0]       cdb_q;
    logic [7:0]             out_data_q;

    logic                   accept;
    logic                   op_load, op_store, op_input, op_output;
    logic [MEM_DEPTH_W-1:0] addr_idx;
    logic                   addr_in_range;

    assign op_load   = i_opcode inside {I_LOAD, I_LOADB, I_LOADR, I_LOADT, I_LOADTB};
    assign op_store  = i_opcode inside {I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB};
    assign op_input  = (i_opcode == I_INPUT);
    assign op_output = (i_opcode == I_OUTPUT);

    assign addr_idx      = i_address[MEM_DEPTH_W-1:0];
    assign addr_in_range = (i_address[DATA_W-1:MEM_DEPTH_W] == '0);

    // Gated by rst so a request held during reset never writes the RAM.
    assign accept = i_valid && (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (op_load) begin
                        state_nxt = READ;
                    end else if (op_input) begin
                        state_nxt = IN_WAIT;
                    end else if (op_output) begin
                        state_nxt = OUT_WAIT;
                    end
                end
            end
            READ:     state_nxt = RESP;
            RESP:     if (o_cdb_ready) state_nxt = IDLE;
            IN_WAIT:  if (in_valid) state_nxt = RESP;
            OUT_WAIT: if (out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_ready     = (state == IDLE) && !rst;
        o_cdb_valid = (state == RESP);
        in_ready    = (state == IN_WAIT);
        out_valid   = (state == OUT_WAIT);
        o_cdb       = cdb_q;
        out_data    = out_data_q;
    end

    always_ff @(posedge clk) begin
        if (accept && op_store && addr_in_range) begin
            mem[addr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_idx      <= '0;
            req_in_range <= 1'b0;
            req_rsv      <= '0;
            cdb_q        <= '0;
            out_data_q   <= '0;
        end else begin
            if (accept) begin
                req_idx      <= addr_idx;
                req_in_range <= addr_in_range;
                req_rsv      <= i_rsv_id;
                if (op_output) begin
                    out_data_q <= i_data[7:0];
                end
            end
            if (state == READ) begin
                cdb_q <= {req_rsv, req_in_range ? mem[req_idx] : {DATA_W{1'b0}}};
            end else if (state == IN_WAIT && in_valid) begin
                cdb_q <= {req_rsv, {(DATA_W-8){1'b0}}, in_data};
            end
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder: RAM load/store, CDB
// back-pressure, out-of-range addresses, byte-stream IO and async reset.

module tb_memory_responder;
    import fcpu_pkg::*;

    localparam int MEM_DEPTH_W = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_valid;
    logic [INSTR_W-1:0]  i_opcode;
    logic [RSV_ID_W-1:0] i_rsv_id;
    logic [DATA_W-1:0]   i_address;
    logic [DATA_W-1:0]   i_data;
    logic                i_ready;
    logic [CDB_W-1:0]    o_cdb;
    logic                o_cdb_valid;
    logic                o_cdb_ready;
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic                out_valid;
    logic [7:0]          out_data;
    logic                out_ready;

    int unsigned errors = 0;
    int unsigned checks = 0;

    memory_responder #(.MEM_DEPTH_W(MEM_DEPTH_W)) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_opcode(i_opcode),
        .i_rsv_id(i_rsv_id),
        .i_address(i_address),
        .i_data(i_data),
        .i_ready(i_ready),
        .o_cdb(o_cdb),
        .o_cdb_valid(o_cdb_valid),
        .o_cdb_ready(o_cdb_ready),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
        i_valid   = 1'b1;
        i_opcode  = I_STORE;
        i_address = addr;
        i_data    = data;
        tick();
        i_valid = 1'b0;
        check("store_stays_idle", 64'(i_ready), 64'd1);
    endtask

    // Load accepted at the next edge; result expected one edge later, then released.
    task automatic do_load(input string tag, input logic [DATA_W-1:0] addr,
                           input logic [RSV_ID_W-1:0] id, input logic [DATA_W-1:0] exp);
        i_valid   = 1'b1;
        i_opcode  = I_LOAD;
        i_address = addr;
        i_rsv_id  = id;
        i_data    = 32'hFFFF_FFFF;
        tick();
        i_valid = 1'b0;
        check({tag, "_read_no_valid"}, 64'(o_cdb_valid), 64'd0);
        check({tag, "_read_not_ready"}, 64'(i_ready), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(o_cdb_valid), 64'd1);
        check({tag, "_cdb"}, 64'(o_cdb), 64'({id, exp}));
        o_cdb_ready = 1'b1;
        tick();
        o_cdb_ready = 1'b0;
        check({tag, "_released"}, 64'(o_cdb_valid), 64'd0);
        check({tag, "_idle"}, 64'(i_ready), 64'd1);
    endtask

    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_opcode    = I_NOP;
        i_rsv_id    = '0;
        i_address   = '0;
        i_data      = '0;
        o_cdb_ready = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        #1;
        check("rst_cdb_valid", 64'(o_cdb_valid), 64'd0);
        check("rst_cdb", 64'(o_cdb), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_i_ready", 64'(i_ready), 64'd1);

        // Seed index 0, then a store held through reset must be ignored
        do_store(32'h0, 32'h1111_1111);
        rst       = 1'b1;
        i_valid   = 1'b1;
        i_opcode  = I_STORE;
        i_address = 32'h0;
        i_data    = 32'h0000_0BAD;
        tick();
        tick();
        i_valid = 1'b0;
        rst     = 1'b0;
        tick();
        do_load("ram_kept", 32'h0, 4'd1, 32'h1111_1111);

        // Store then load next cycle
        do_store(32'h10, 32'hDEAD_BEEF);
        do_load("st_ld", 32'h10, 4'd3, 32'hDEAD_BEEF);

        // Back-to-back stores
        do_store(32'h20, 32'hA5A5_A5A5);
        do_store(32'h21, 32'h5A5A_5A5A);
        do_load("b2b_a", 32'h20, 4'd4, 32'hA5A5_A5A5);
        do_load("b2b_b", 32'h21, 4'd6, 32'h5A5A_5A5A);

        // Back-pressure: hold o_cdb_ready low for 5 cycles
        i_valid   = 1'b1;
        i_opcode  = I_LOADT;
        i_address = 32'h10;
        i_rsv_id  = 4'd7;
        tick();
        i_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(o_cdb_valid), 64'd1);
            check("bp_cdb", 64'(o_cdb), 64'({4'd7, 32'hDEAD_BEEF}));
            check("bp_i_ready", 64'(i_ready), 64'd0);
            tick();
        end
        o_cdb_ready = 1'b1;
        tick();
        o_cdb_ready = 1'b0;
        check("bp_released", 64'(o_cdb_valid), 64'd0);

        // Out-of-range address
        do_store(32'h400, 32'hCAFE_F00D);
        do_load("oor_load", 32'h400, 4'd2, 32'h0);
        do_load("oor_idx0", 32'h0, 4'd2, 32'h1111_1111);

        // Unrecognised opcode is swallowed without a response
        i_valid  = 1'b1;
        i_opcode = I_ADD;
        tick();
        i_valid = 1'b0;
        check("other_idle", 64'(i_ready), 64'd1);
        tick();
        check("other_no_cdb", 64'(o_cdb_valid), 64'd0);

        // Input stream
        i_valid  = 1'b1;
        i_opcode = I_INPUT;
        i_rsv_id = 4'd5;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("in_wait_ready", 64'(in_ready), 64'd1);
            check("in_wait_no_cdb", 64'(o_cdb_valid), 64'd0);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h41;
        tick();
        in_valid = 1'b0;
        check("in_done_ready", 64'(in_ready), 64'd0);
        check("in_cdb_valid", 64'(o_cdb_valid), 64'd1);
        check("in_cdb", 64'(o_cdb), 64'({4'd5, 32'h0000_0041}));
        o_cdb_ready = 1'b1;
        tick();
        o_cdb_ready = 1'b0;
        check("in_released", 64'(i_ready), 64'd1);

        // Output stream
        i_valid  = 1'b1;
        i_opcode = I_OUTPUT;
        i_data   = 32'h0000_1234;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("out_valid", 64'(out_valid), 64'd1);
            check("out_data", 64'(out_data), 64'h34);
            check("out_no_cdb", 64'(o_cdb_valid), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_done", 64'(out_valid), 64'd0);
        check("out_idle", 64'(i_ready), 64'd1);
        check("out_no_cdb_after", 64'(o_cdb_valid), 64'd0);

        // Async reset while a response is pending
        i_valid   = 1'b1;
        i_opcode  = I_LOAD;
        i_address = 32'h10;
        i_rsv_id  = 4'd9;
        tick();
        i_valid = 1'b0;
        tick();
        check("ar_resp_valid", 64'(o_cdb_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid_low", 64'(o_cdb_valid), 64'd0);
        check("ar_cdb_zero", 64'(o_cdb), 64'd0);
        tick();
        rst         = 1'b0;
        o_cdb_ready = 1'b1;
        #1;
        check("ar_idle", 64'(i_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_resp", 64'(o_cdb_valid), 64'd0);
        end
        o_cdb_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
